grid_world_engine: RTL and testbench
====================================

Name: grid_world_engine

Overview:
- Parametrised successor of the top-level world simulator for the pipe-cleaning robot.
- Holds an ROWS x COLS cell map and the robot pose, and presents head/left/under/barrier sensors to the robot core.
- Accepts robot actions over a valid handshake and applies moves, left turns and multi-cycle trash removal.
- Adds what the old world lacked: a runtime map load port, collision detection, a step limit, and statistics counters.

Parameters:
ROWS, 10, map rows (external coordinates 1..ROWS)
COLS, 20, map columns (external coordinates 1..COLS)
ROW_W, 6, width of row coordinate
COL_W, 6, width of column coordinate
ADDR_W, 8, map address width; must satisfy 2^ADDR_W >= ROWS*COLS
REMOVE_CYCLES, 3, consecutive remove actions needed to clear a barrier (>=1)
CNT_W, 16, width of step/collision/removal counters
MAX_STEPS, 1000, steps before automatic stop; 0 = unlimited

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
map_we  in  1  map write strobe (honoured only in IDLE or DONE)
map_addr  in  ADDR_W  cell address = (row-1)*COLS + (col-1)
map_wdata  in  3  cell code: 0 free, 1 wall, 2 barrier/trash, 7 dirt marker, others treated as free
start  in  1  one-cycle pulse; loads pose and begins run (IDLE or DONE only)
init_row  in  ROW_W  starting row
init_col  in  COL_W  starting column
init_orient  in  2  starting orientation: 00 N, 01 S, 10 E, 11 W
sensors_valid  out  1  head/left/under/barrier valid, waiting for action
head  out  1  wall or map edge directly ahead
left  out  1  wall or map edge on robot's left
under  out  1  current cell is 7
barrier  out  1  cell ahead is 2 (never 1 at map edge)
action_valid  in  1  robot action present
front  in  1  move forward one cell
turn  in  1  rotate left 90 degrees
remove  in  1  work on barrier ahead
robot_row  out  ROW_W  current row
robot_col  out  COL_W  current column
robot_orient  out  2  current orientation
collision  out  1  one-cycle pulse on a rejected forward move
done  out  1  step limit reached
step_count  out  CNT_W  accepted actions since start
collision_count  out  CNT_W  rejected forward moves since start
removed_count  out  CNT_W  barriers cleared since start

Behaviour:
- Reset (async): state=IDLE; all outputs 0; pose=(1,1,N); removal counter 0. Map contents are NOT cleared by reset.
- FSM states: IDLE, SENSE, WAIT_ACT, APPLY, DONE.
- IDLE/DONE:
  - map_we writes map_wdata to map_addr; addresses >= ROWS*COLS are ignored.
  - start latches the init pose, clears all counters, done=0, goes to SENSE.
  - If start and map_we are high together, the write happens and the run starts the same cycle.
- SENSE (1 cycle): registers the four sensors from pose and map, then goes to WAIT_ACT.
  - Sensors are relative to orientation. Left: N->west, S->east, E->north, W->south.
  - Off-map neighbours read as wall for head/left and never as barrier.
- WAIT_ACT: sensors_valid=1 and the sensors are held stable. When action_valid=1, front/turn/remove are sampled, sensors_valid=0 next cycle, go to APPLY.
- APPLY (1 cycle):
  - Priority: front > turn > remove; lower-priority requests are ignored. No request set = no-op step.
  - front: if head=0 and barrier=0, advance one cell. Otherwise pose is unchanged, collision pulses 1 cycle, collision_count+1.
  - turn: N->W, W->S, S->E, E->N.
  - remove:
    - Removal counter increments. When it reaches REMOVE_CYCLES and the cell ahead is 2, the cell is written to 0, removed_count+1, and the counter resets.
    - If barrier=0, remove is a no-op and the counter resets.
  - Any accepted action other than remove resets the removal counter.
  - step_count+1 on every APPLY. If MAX_STEPS!=0 and step_count reaches MAX_STEPS, go to DONE with done=1; otherwise go to SENSE.
- Latency: action sampled at edge N; pose and map update at N+1; sensors_valid reasserted at N+3.
- Counters saturate at all-ones.
- start during an active run is ignored.
- Reset mid-run aborts immediately; the map keeps any cleared cells.

Test Plan:
- All cells 0, start (5,5,N), 3x front -> pose (2,5,N), step_count=3, sensors_valid high 3 cycles after each action.
- Start (1,1,N), front -> collision pulse, pose (1,1), collision_count=1; then turn x4 -> orient W,S,E,N in order.
- Cell (4,5)=2, start (5,5,N): barrier=1, head=0; front -> collision_count=1.
  - Then remove x2 -> cell still 2.
  - Third remove -> cell (4,5)=0, removed_count=1, next SENSE barrier=0.
- Remove, remove, turn, remove with barrier ahead -> no clear; counter restarts after the turn.
- MAX_STEPS=4: five actions -> done=1 after the fourth, sensors_valid stays 0, map_we accepted again.
- Cell (5,5)=7, start there -> under=1; assert reset in WAIT_ACT -> outputs 0, map cell still 7.

Source files
------------

// File: rtl/grid_world_engine.sv
// Grid world simulator for the pipe-cleaning robot.
// Ports: clock/reset, map load (map_we/addr/wdata), start + init pose,
//   sensor bundle (sensors_valid/head/left/under/barrier), action
//   handshake (action_valid/front/turn/remove), pose, collision/done and
//   step/collision/removal counters.
module grid_world_engine #(
  parameter int ROWS          = 10,
  parameter int COLS          = 20,
  parameter int ROW_W         = 6,
  parameter int COL_W         = 6,
  parameter int ADDR_W        = 8,
  parameter int REMOVE_CYCLES = 3,
  parameter int CNT_W         = 16,
  parameter int MAX_STEPS     = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              map_we,
  input  logic [ADDR_W-1:0] map_addr,
  input  logic [2:0]        map_wdata,
  input  logic              start,
  input  logic [ROW_W-1:0]  init_row,
  input  logic [COL_W-1:0]  init_col,
  input  logic [1:0]        init_orient,
  output logic              sensors_valid,
  output logic              head,
  output logic              left,
  output logic              under,
  output logic              barrier,
  input  logic              action_valid,
  input  logic              front,
  input  logic              turn,
  input  logic              remove,
  output logic [ROW_W-1:0]  robot_row,
  output logic [COL_W-1:0]  robot_col,
  output logic [1:0]        robot_orient,
  output logic              collision,
  output logic              done,
  output logic [CNT_W-1:0]  step_count,
  output logic [CNT_W-1:0]  collision_count,
  output logic [CNT_W-1:0]  removed_count
);

  localparam int CELLS = ROWS * COLS;
  localparam int RC_W  = $clog2(REMOVE_CYCLES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SENSE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_APPLY = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] D_N = 2'b00;
  localparam logic [1:0] D_S = 2'b01;
  localparam logic [1:0] D_E = 2'b10;
  localparam logic [1:0] D_W = 2'b11;

  localparam logic [ROW_W-1:0]  R_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0]  R_MAX  = ROW_W'(ROWS);
  localparam logic [COL_W-1:0]  C_ONE  = COL_W'(1);
  localparam logic [COL_W-1:0]  C_MAX  = COL_W'(COLS);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_COLS = ADDR_W'(COLS);
  localparam logic [ADDR_W:0]   A_LIM  = (ADDR_W + 1)'(CELLS);
  localparam logic [RC_W-1:0]   RC_MAX = RC_W'(REMOVE_CYCLES);
  localparam logic [CNT_W-1:0]  S_LIM  = CNT_W'(MAX_STEPS);

  logic [2:0] map_mem [CELLS];

  logic [2:0]        state;
  logic [RC_W-1:0]   rm_cnt, rm_nxt;
  logic              act_front, act_turn, act_remove;
  logic              idle_like, clear_en;
  logic              ahead_off, left_off;
  logic [ROW_W-1:0]  ahead_r, left_r;
  logic [COL_W-1:0]  ahead_c, left_c;
  logic [ADDR_W-1:0] ahead_addr;
  logic [2:0]        ahead_cell, left_cell, here_cell;
  logic [CNT_W-1:0]  step_next;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_data;

  function automatic logic [ADDR_W-1:0] addr_of(
    input logic [ROW_W-1:0] r,
    input logic [COL_W-1:0] c
  );
    return (ADDR_W'(r) - A_ONE) * A_COLS + ADDR_W'(c) - A_ONE;
  endfunction

  // Left of a heading equals the heading after a left turn.
  function automatic logic [1:0] left_of(input logic [1:0] d);
    unique case (d)
      D_N:     return D_W;
      D_W:     return D_S;
      D_S:     return D_E;
      default: return D_N;
    endcase
  endfunction

  // Neighbour in direction d; returns 1 when it lies off the map.
  function automatic logic nbr(
    input  logic [1:0]       d,
    input  logic [ROW_W-1:0] r,
    input  logic [COL_W-1:0] c,
    output logic [ROW_W-1:0] nr,
    output logic [COL_W-1:0] nc
  );
    logic off;
    nr = r;
    nc = c;
    unique case (d)
      D_N: begin off = (r == R_ONE); nr = r - R_ONE; end
      D_S: begin off = (r == R_MAX); nr = r + R_ONE; end
      D_E: begin off = (c == C_MAX); nc = c + C_ONE; end
      default: begin off = (c == C_ONE); nc = c - C_ONE; end
    endcase
    return off;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    ahead_r    = robot_row;
    ahead_c    = robot_col;
    left_r     = robot_row;
    left_c     = robot_col;
    ahead_off  = nbr(robot_orient, robot_row, robot_col,
                     ahead_r, ahead_c);
    left_off   = nbr(left_of(robot_orient), robot_row, robot_col,
                     left_r, left_c);
    ahead_addr = addr_of(ahead_r, ahead_c);
    ahead_cell = ahead_off ? 3'd0 : map_mem[ahead_addr];
    left_cell  = left_off ? 3'd0 : map_mem[addr_of(left_r, left_c)];
    here_cell  = map_mem[addr_of(robot_row, robot_col)];
  end

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign rm_nxt    = rm_cnt + RC_W'(1);
  assign step_next = sat_inc(step_count);
  // Barrier is the registered view of the cell ahead; the map only
  // changes during a run through this clear path.
  assign clear_en  = (state == S_APPLY) && !act_front && !act_turn &&
                     act_remove && barrier && (rm_nxt == RC_MAX);

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = map_addr;
    mem_data = map_wdata;
    if (clear_en) begin
      mem_we   = 1'b1;
      mem_addr = ahead_addr;
      mem_data = 3'd0;
    end else if (idle_like && map_we && ({1'b0, map_addr} < A_LIM)) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) map_mem[mem_addr] <= mem_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      sensors_valid   <= 1'b0;
      head            <= 1'b0;
      left            <= 1'b0;
      under           <= 1'b0;
      barrier         <= 1'b0;
      robot_row       <= R_ONE;
      robot_col       <= C_ONE;
      robot_orient    <= D_N;
      collision       <= 1'b0;
      done            <= 1'b0;
      step_count      <= '0;
      collision_count <= '0;
      removed_count   <= '0;
      rm_cnt          <= '0;
      act_front       <= 1'b0;
      act_turn        <= 1'b0;
      act_remove      <= 1'b0;
    end else begin
      collision <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            robot_row       <= init_row;
            robot_col       <= init_col;
            robot_orient    <= init_orient;
            step_count      <= '0;
            collision_count <= '0;
            removed_count   <= '0;
            rm_cnt          <= '0;
            done            <= 1'b0;
            state           <= S_SENSE;
          end
        end
        S_SENSE: begin
          head    <= ahead_off || (ahead_cell == 3'd1);
          barrier <= !ahead_off && (ahead_cell == 3'd2);
          left    <= left_off || (left_cell == 3'd1);
          under   <= (here_cell == 3'd7);
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // Valid rises one cycle into WAIT so it lands three cycles
          // after the accepting edge.
          if (sensors_valid && action_valid) begin
            act_front     <= front;
            act_turn      <= turn;
            act_remove    <= remove;
            sensors_valid <= 1'b0;
            state         <= S_APPLY;
          end else begin
            sensors_valid <= 1'b1;
          end
        end
        S_APPLY: begin
          if (act_front) begin
            rm_cnt <= '0;
            if (!head && !barrier) begin
              robot_row <= ahead_r;
              robot_col <= ahead_c;
            end else begin
              collision       <= 1'b1;
              collision_count <= sat_inc(collision_count);
            end
          end else if (act_turn) begin
            rm_cnt       <= '0;
            robot_orient <= left_of(robot_orient);
          end else if (act_remove) begin
            if (!barrier) begin
              rm_cnt <= '0;
            end else if (rm_nxt == RC_MAX) begin
              rm_cnt        <= '0;
              removed_count <= sat_inc(removed_count);
            end else begin
              rm_cnt <= rm_nxt;
            end
          end else begin
            rm_cnt <= '0;
          end
          step_count <= step_next;
          if ((MAX_STEPS != 0) && (step_next >= S_LIM)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_SENSE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_world_engine.sv
// Bench for grid_world_engine: scoreboarded action sequences on a
// default instance plus a MAX_STEPS=4 instance sharing the stimulus.
module tb_grid_world_engine;

  typedef struct {
    logic [5:0]  row;
    logic [5:0]  col;
    logic [1:0]  ori;
    logic        coll;
    logic [15:0] steps;
    logic [15:0] colls;
    logic [15:0] rem;
    logic        head;
    logic        bar;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        map_we = 1'b0;
  logic [7:0]  map_addr = '0;
  logic [2:0]  map_wdata = '0;
  logic        start = 1'b0;
  logic [5:0]  init_row = '0;
  logic [5:0]  init_col = '0;
  logic [1:0]  init_orient = '0;
  logic        action_valid = 1'b0;
  logic        front = 1'b0;
  logic        turn = 1'b0;
  logic        remove = 1'b0;

  logic        sensors_valid, head, left, under, barrier;
  logic [5:0]  robot_row, robot_col;
  logic [1:0]  robot_orient;
  logic        collision, done;
  logic [15:0] step_count, collision_count, removed_count;

  logic        sv_4, head_4, left_4, under_4, bar_4;
  logic [5:0]  row_4, col_4;
  logic [1:0]  ori_4;
  logic        coll_4, done_4;
  logic [15:0] steps_4, colls_4, rem_4;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  grid_world_engine dut (
    .clock(clock), .reset(reset),
    .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata),
    .start(start), .init_row(init_row), .init_col(init_col),
    .init_orient(init_orient),
    .sensors_valid(sensors_valid), .head(head), .left(left),
    .under(under), .barrier(barrier),
    .action_valid(action_valid), .front(front), .turn(turn),
    .remove(remove),
    .robot_row(robot_row), .robot_col(robot_col),
    .robot_orient(robot_orient),
    .collision(collision), .done(done), .step_count(step_count),
    .collision_count(collision_count), .removed_count(removed_count)
  );

  grid_world_engine #(.MAX_STEPS(4)) dut4 (
    .clock(clock), .reset(reset),
    .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata),
    .start(start), .init_row(init_row), .init_col(init_col),
    .init_orient(init_orient),
    .sensors_valid(sv_4), .head(head_4), .left(left_4),
    .under(under_4), .barrier(bar_4),
    .action_valid(action_valid), .front(front), .turn(turn),
    .remove(remove),
    .robot_row(row_4), .robot_col(col_4), .robot_orient(ori_4),
    .collision(coll_4), .done(done_4), .step_count(steps_4),
    .collision_count(colls_4), .removed_count(rem_4)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  function automatic exp_t mk(int r, int c, int o, int cl, int s,
                              int cc, int rm, int h, int b);
    exp_t e;
    e.row = 6'(r); e.col = 6'(c); e.ori = 2'(o); e.coll = 1'(cl);
    e.steps = 16'(s); e.colls = 16'(cc); e.rem = 16'(rm);
    e.head = 1'(h); e.bar = 1'(b);
    return e;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic write_cell(input int r, input int c, input int v);
    map_we    = 1'b1;
    map_addr  = 8'((r - 1) * 20 + (c - 1));
    map_wdata = 3'(v);
    @(negedge clock);
    map_we = 1'b0;
  endtask

  task automatic clear_map();
    for (int i = 0; i < 200; i++) begin
      map_we    = 1'b1;
      map_addr  = 8'(i);
      map_wdata = 3'd0;
      @(negedge clock);
    end
    map_we = 1'b0;
  endtask

  task automatic start_run(input int r, input int c, input int o);
    start       = 1'b1;
    init_row    = 6'(r);
    init_col    = 6'(c);
    init_orient = 2'(o);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_sv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sensors_valid) begin
        ok = 1'b1;
        return;
      end
      @(negedge clock);
    end
  endtask

  task automatic act(input logic f, input logic t, input logic r,
                     input exp_t e);
    exp_t x;
    bit   ok;
    int   k;
    logic cp;
    sb.push_back(e);
    wait_sv(ok);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL act_wait: sensors_valid never rose");
      x = sb.pop_front();
      return;
    end
    action_valid = 1'b1;
    front = f; turn = t; remove = r;
    @(negedge clock);
    action_valid = 1'b0;
    front = 1'b0; turn = 1'b0; remove = 1'b0;
    k  = 1;
    cp = 1'b0;
    checks++;
    if (sensors_valid !== 1'b0) begin
      errors++;
      $display("FAIL act_drop: sensors_valid=%b want 0", sensors_valid);
    end
    while (!sensors_valid && k < 12) begin
      @(negedge clock);
      k++;
      if (k == 2) cp = collision;
    end
    x = sb.pop_front();
    checks++;
    if (k !== 4) begin
      errors++;
      $display("FAIL act_latency: %0d cycles want 4", k);
    end
    checks++;
    if ({robot_row, robot_col, robot_orient} !== {x.row, x.col, x.ori}) begin
      errors++;
      $display("FAIL act_pose: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
               robot_row, robot_col, robot_orient, x.row, x.col, x.ori);
    end
    checks++;
    if (cp !== x.coll) begin
      errors++;
      $display("FAIL act_collision: got %b want %b", cp, x.coll);
    end
    checks++;
    if ({step_count, collision_count, removed_count} !==
        {x.steps, x.colls, x.rem}) begin
      errors++;
      $display("FAIL act_counts: got %0d/%0d/%0d want %0d/%0d/%0d",
               step_count, collision_count, removed_count,
               x.steps, x.colls, x.rem);
    end
    checks++;
    if ({head, barrier} !== {x.head, x.bar}) begin
      errors++;
      $display("FAIL act_sensors: head/barrier=%b%b want %b%b",
               head, barrier, x.head, x.bar);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({sensors_valid, head, left, under, barrier, collision, done}
        !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0",
               {sensors_valid, head, left, under, barrier, collision, done});
    end
    checks++;
    if ({robot_row, robot_col, robot_orient} !== {6'd1, 6'd1, 2'd0}) begin
      errors++;
      $display("FAIL reset_pose: got (%0d,%0d,%0d) want (1,1,0)",
               robot_row, robot_col, robot_orient);
    end
    checks++;
    if ({step_count, collision_count, removed_count} !== 48'd0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0",
               step_count, collision_count, removed_count);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_forward();
    bit ok;
    do_reset();
    clear_map();
    start_run(5, 5, 0);
    wait_sv(ok);
    checks++;
    if (!ok || {head, left, under, barrier} !== 4'b0000) begin
      errors++;
      $display("FAIL fwd_sense: ok=%b hlub=%b want 0000", ok,
               {head, left, under, barrier});
    end
    act(1, 0, 0, mk(4, 5, 0, 0, 1, 0, 0, 0, 0));
    act(1, 0, 0, mk(3, 5, 0, 0, 2, 0, 0, 0, 0));
    act(1, 0, 0, mk(2, 5, 0, 0, 3, 0, 0, 0, 0));
  endtask

  task automatic test_collision_turn();
    bit ok;
    do_reset();
    start_run(1, 1, 0);
    wait_sv(ok);
    checks++;
    if (!ok || {head, left, barrier} !== 3'b110) begin
      errors++;
      $display("FAIL edge_sense: ok=%b h/l/b=%b want 110", ok,
               {head, left, barrier});
    end
    act(1, 0, 0, mk(1, 1, 0, 1, 1, 1, 0, 1, 0));
    act(0, 1, 0, mk(1, 1, 3, 0, 2, 1, 0, 1, 0));
    act(0, 1, 0, mk(1, 1, 1, 0, 3, 1, 0, 0, 0));
    act(0, 1, 0, mk(1, 1, 2, 0, 4, 1, 0, 0, 0));
    act(0, 1, 0, mk(1, 1, 0, 0, 5, 1, 0, 1, 0));
  endtask

  task automatic test_remove();
    bit ok;
    do_reset();
    write_cell(4, 5, 2);
    start_run(5, 5, 0);
    wait_sv(ok);
    checks++;
    if (!ok || {head, barrier} !== 2'b01) begin
      errors++;
      $display("FAIL rm_sense: ok=%b head/barrier=%b want 01", ok,
               {head, barrier});
    end
    act(1, 0, 0, mk(5, 5, 0, 1, 1, 1, 0, 0, 1));
    act(0, 0, 1, mk(5, 5, 0, 0, 2, 1, 0, 0, 1));
    act(0, 0, 1, mk(5, 5, 0, 0, 3, 1, 0, 0, 1));
    act(0, 0, 1, mk(5, 5, 0, 0, 4, 1, 1, 0, 0));
    act(1, 0, 0, mk(4, 5, 0, 0, 5, 1, 1, 0, 0));
  endtask

  task automatic test_remove_interrupt();
    do_reset();
    write_cell(4, 5, 2);
    start_run(5, 5, 0);
    act(0, 0, 1, mk(5, 5, 0, 0, 1, 0, 0, 0, 1));
    act(0, 0, 1, mk(5, 5, 0, 0, 2, 0, 0, 0, 1));
    act(0, 1, 0, mk(5, 5, 3, 0, 3, 0, 0, 0, 0));
    act(0, 1, 0, mk(5, 5, 1, 0, 4, 0, 0, 0, 0));
    act(0, 1, 0, mk(5, 5, 2, 0, 5, 0, 0, 0, 0));
    act(0, 1, 0, mk(5, 5, 0, 0, 6, 0, 0, 0, 1));
    act(0, 0, 1, mk(5, 5, 0, 0, 7, 0, 0, 0, 1));
    act(0, 0, 1, mk(5, 5, 0, 0, 8, 0, 0, 0, 1));
    act(0, 0, 1, mk(5, 5, 0, 0, 9, 0, 1, 0, 0));
  endtask

  task automatic test_step_limit();
    int k;
    do_reset();
    start_run(5, 5, 0);
    act(0, 1, 0, mk(5, 5, 3, 0, 1, 0, 0, 0, 0));
    act(0, 1, 0, mk(5, 5, 1, 0, 2, 0, 0, 0, 0));
    act(0, 1, 0, mk(5, 5, 2, 0, 3, 0, 0, 0, 0));
    act(0, 1, 0, mk(5, 5, 0, 0, 4, 0, 0, 0, 0));
    checks++;
    if ({done_4, sv_4, steps_4} !== {1'b1, 1'b0, 16'd4}) begin
      errors++;
      $display("FAIL limit_done: done=%b valid=%b steps=%0d want 1 0 4",
               done_4, sv_4, steps_4);
    end
    act(0, 1, 0, mk(5, 5, 3, 0, 5, 0, 0, 0, 0));
    checks++;
    if ({done_4, sv_4, steps_4, ori_4} !== {1'b1, 1'b0, 16'd4, 2'd0}) begin
      errors++;
      $display("FAIL limit_hold: done=%b valid=%b steps=%0d ori=%0d want 1 0 4 0",
               done_4, sv_4, steps_4, ori_4);
    end
    write_cell(5, 5, 7);
    start_run(5, 5, 2);
    k = 0;
    while (!sv_4 && k < 20) begin
      @(negedge clock);
      k++;
    end
    checks++;
    if ({sv_4, done_4, under_4, steps_4} !== {3'b101, 16'd0}) begin
      errors++;
      $display("FAIL limit_reload: valid=%b done=%b under=%b steps=%0d want 1 0 1 0",
               sv_4, done_4, under_4, steps_4);
    end
    checks++;
    if ({sensors_valid, robot_orient, step_count} !== {1'b1, 2'd3, 16'd5}) begin
      errors++;
      $display("FAIL start_ignored: valid=%b ori=%0d steps=%0d want 1 3 5",
               sensors_valid, robot_orient, step_count);
    end
    act(0, 1, 0, mk(5, 5, 1, 0, 6, 0, 0, 0, 0));
    checks++;
    if (under !== 1'b0) begin
      errors++;
      $display("FAIL busy_write: under=%b want 0", under);
    end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    do_reset();
    write_cell(5, 5, 7);
    start_run(5, 5, 0);
    wait_sv(ok);
    checks++;
    if (!ok || {under, barrier} !== 2'b10) begin
      errors++;
      $display("FAIL dirt_sense: ok=%b under/barrier=%b want 10", ok,
               {under, barrier});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({sensors_valid, under, robot_row, robot_col, robot_orient,
         step_count} !== {2'b00, 6'd1, 6'd1, 2'd0, 16'd0}) begin
      errors++;
      $display("FAIL midrun_reset: valid=%b under=%b pose=(%0d,%0d,%0d) steps=%0d",
               sensors_valid, under, robot_row, robot_col, robot_orient,
               step_count);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    start_run(5, 5, 2);
    wait_sv(ok);
    checks++;
    if (!ok || under !== 1'b1) begin
      errors++;
      $display("FAIL map_kept: ok=%b under=%b want 1", ok, under);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_collision_turn();
    test_remove();
    test_remove_interrupt();
    test_step_limit();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
